canny_frame_ctrl: RTL and testbench
===================================

// Module: canny_frame_ctrl
// PURPOSE
//  Frame sequencer for the Canny edge-detect pipeline. Sits between the external pixel
//  source and the pipeline input FIFO (24-bit RGB), and monitors the output FIFO read side.
//  Admits exactly WIDTH*HEIGHT pixels per armed frame and counts the same number of
//  processed pixels leaving the pipeline. Signals busy and frame_done so software or a
//  testbench can run frames back to back.
// PARAMETERS
//  WIDTH       720      image width in pixels
//  HEIGHT      540      image height in pixels
//  PIX_CNT_W   20       pixel counter width; must satisfy 2**PIX_CNT_W > WIDTH*HEIGHT
//  WDT_CYCLES  1048576  stall limit in cycles (used only with CANNY_FRAME_WDT_EN)
// PORTS
//  clock          in   1          system clock; all logic on rising edge
//  reset          in   1          asynchronous, active-high reset
//  start          in   1          arm one frame; sampled only in IDLE
//  busy           out  1          1 in LOAD and DRAIN
//  frame_done     out  1          one-cycle pulse when the frame's last output pixel is read
//  timeout        out  1          sticky watchdog abort flag
//  src_valid      in   1          source pixel valid
//  src_data       in   24         source RGB pixel
//  src_ready      out  1          controller accepts a pixel when src_valid && src_ready
//  image_wr_en    out  1          write enable to the input FIFO
//  image_din      out  24         input FIFO data; equals src_data (combinational pass-through)
//  image_full     in   1          input FIFO full
//  img_out_empty  in   1          output FIFO empty (monitor only)
//  img_out_rd_en  in   1          consumer read of the output FIFO (monitor only)
//  in_count       out  PIX_CNT_W  pixels accepted in the current/last frame
//  out_count      out  PIX_CNT_W  pixels read out in the current/last frame
// BEHAVIOUR
//  - TOTAL = WIDTH*HEIGHT. State machine states: IDLE, LOAD, DRAIN, DONE.
//  - Reset: state=IDLE; busy, frame_done, timeout, src_ready, image_wr_en = 0;
//    in_count and out_count = 0. Reset mid-frame abandons the frame; the pipeline FIFOs are reset by the same signal.
//  - IDLE: on start=1, clear both counts and go to LOAD. src_ready is 1 from the next cycle.
//  - src_ready = (state==LOAD) && !image_full. This is combinational and has no same-cycle
//    dependence on src_valid.
//  - image_wr_en = src_valid && src_ready. An accepted beat increments in_count.
//    The beat that makes in_count==TOTAL moves LOAD to DRAIN, so src_ready is 0 after it.
//  - An output beat is img_out_rd_en && !img_out_empty. Output beats are counted in LOAD
//    and DRAIN only, because output can begin before input completes. Beats in IDLE or DONE are ignored.
//  - The output beat that makes out_count==TOTAL moves to DONE. If it arrives while still
//    in LOAD, the controller moves to DONE once in_count also reaches TOTAL.
//  - An input beat and an output beat in the same cycle are both counted.
//  - DONE lasts one cycle: frame_done=1, busy=0, then IDLE. frame_done is registered.
//  - start is ignored outside IDLE, including in the DONE cycle.
//  - Counts hold their final values in IDLE until the next start.
//  - Counters saturate at TOTAL and never wrap.
// CONFIGURATION
//  CANNY_FRAME_WDT_EN defined:
//  - A stall counter runs in LOAD/DRAIN. It clears on any input or output beat and on start.
//  - When it reaches WDT_CYCLES-1: set timeout=1 and go to IDLE without a frame_done pulse.
//  - timeout stays set until the next accepted start, which clears it.
//  CANNY_FRAME_WDT_EN undefined: no stall counter; timeout tied to 0.
// TESTING  (WIDTH=4, HEIGHT=2, TOTAL=8, WDT_CYCLES=16)
//  1. Reset held 3 cycles -> busy, frame_done, src_ready, image_wr_en, timeout, counts = 0.
//  2. start pulse; 8 pixels 0x000001..0x000008 with src_valid=1; sink always reading ->
//     image_din matches in order; in_count=8 and src_ready=0 after the 8th beat;
//     one frame_done pulse on the cycle after the 8th output read; busy=0 after it.
//  3. image_full=1 for 5 cycles after pixel 3 -> src_ready=0 and image_wr_en=0 throughout;
//     in_count holds at 3; the frame completes with 8 in and 8 out.
//  4. start pulsed during LOAD and DRAIN; src_valid held high after pixel 8 -> no restart;
//     in_count stays 8; exactly one frame_done.
//  5. reset asserted in LOAD with in_count=3 -> IDLE and counts 0 immediately; next start
//     runs a full 8-pixel frame correctly.
//  6. (WDT_EN) source stalls after 3 pixels with no output reads -> timeout=1 on the 16th
//     stall cycle; busy=0; no frame_done; next start clears timeout.

Source files
------------

// File: rtl/canny_frame_ctrl.sv
// Frame sequencer for the Canny pipeline: admits WIDTH*HEIGHT pixels per armed frame and counts them out.
// Optional stall watchdog is compiled in with `define CANNY_FRAME_WDT_EN.
module canny_frame_ctrl #(
    parameter int WIDTH      = 720,
    parameter int HEIGHT     = 540,
    parameter int PIX_CNT_W  = 20,
    parameter int WDT_CYCLES = 1048576
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 timeout,
    input  logic                 src_valid,
    input  logic [23:0]          src_data,
    output logic                 src_ready,
    output logic                 image_wr_en,
    output logic [23:0]          image_din,
    input  logic                 image_full,
    input  logic                 img_out_empty,
    input  logic                 img_out_rd_en,
    output logic [PIX_CNT_W-1:0] in_count,
    output logic [PIX_CNT_W-1:0] out_count
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam logic [PIX_CNT_W-1:0] TOTAL_C = PIX_CNT_W'(TOTAL);

    generate
        if (TOTAL >= (1 << PIX_CNT_W) || WDT_CYCLES < 2) begin : g_bad_cfg
            $error("canny_frame_ctrl: PIX_CNT_W too small or WDT_CYCLES < 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t               state, state_nxt;
    logic                 counting, in_beat, out_beat, wdt_trip;
    logic [PIX_CNT_W-1:0] in_cnt_nxt, out_cnt_nxt;

    function automatic logic [PIX_CNT_W-1:0] sat_inc(input logic [PIX_CNT_W-1:0] v);
        return (v >= TOTAL_C) ? TOTAL_C : v + 1'b1;
    endfunction

    assign counting    = (state == LOAD) || (state == DRAIN);
    assign busy        = counting;
    assign src_ready   = (state == LOAD) && !image_full;
    assign in_beat     = src_valid && src_ready;
    assign image_wr_en = in_beat;
    assign image_din   = src_data;
    // Output reads outside an active frame belong to nobody and are ignored.
    assign out_beat    = counting && img_out_rd_en && !img_out_empty;

    always_comb begin
        state_nxt   = state;
        in_cnt_nxt  = in_count;
        out_cnt_nxt = out_count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = LOAD;
                    in_cnt_nxt  = '0;
                    out_cnt_nxt = '0;
                end
            end
            LOAD, DRAIN: begin
                if (in_beat)  in_cnt_nxt  = sat_inc(in_count);
                if (out_beat) out_cnt_nxt = sat_inc(out_count);
                if (in_cnt_nxt == TOTAL_C && out_cnt_nxt == TOTAL_C) state_nxt = DONE;
                else if (in_cnt_nxt == TOTAL_C)                       state_nxt = DRAIN;
                if (wdt_trip) state_nxt = IDLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_count   <= '0;
            out_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_count   <= in_cnt_nxt;
            out_count  <= out_cnt_nxt;
            frame_done <= (state_nxt == DONE);
        end
    end

`ifdef CANNY_FRAME_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] stall_cnt;
    logic             timeout_q;

    // Trips on the WDT_CYCLES-th consecutive active cycle with no beat in either direction.
    assign wdt_trip = counting && !in_beat && !out_beat &&
                      (stall_cnt == WDT_W'(WDT_CYCLES - 1));
    assign timeout  = timeout_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else if (!counting || in_beat || out_beat) begin
            stall_cnt <= '0;
        end else if (wdt_trip) begin
            stall_cnt <= '0;
            timeout_q <= 1'b1;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign wdt_trip = 1'b0;
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Bench for canny_frame_ctrl (4x2 frame): directed table, corner sequences, random run vs. a count-based model.
module tb_canny_frame_ctrl;

    localparam int TOTAL = 8;
    localparam int PW    = 4;
    localparam int WDT   = 16;

    logic          clock = 1'b0;
    logic          reset, start, src_valid, image_full, img_out_empty, img_out_rd_en;
    logic [23:0]   src_data;
    logic          busy, frame_done, timeout, src_ready, image_wr_en;
    logic [23:0]   image_din;
    logic [PW-1:0] in_count, out_count;

    canny_frame_ctrl #(.WIDTH(4), .HEIGHT(2), .PIX_CNT_W(PW), .WDT_CYCLES(WDT)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
        .timeout(timeout), .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .image_wr_en(image_wr_en), .image_din(image_din), .image_full(image_full),
        .img_out_empty(img_out_empty), .img_out_rd_en(img_out_rd_en),
        .in_count(in_count), .out_count(out_count));

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: frame activity expressed as pixel tallies.
    logic m_active, m_done, m_to;
    int   m_in, m_out, m_stall, pend;
    logic auto_empty;

    typedef struct {
        logic        st, vl;
        logic [23:0] d;
        logic        full, rd, emp;
        logic        e_rdy, e_wr, e_busy, e_done;
        int          e_in, e_out;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        m_active = 1'b0; m_done = 1'b0; m_to = 1'b0;
        m_in = 0; m_out = 0; m_stall = 0; pend = 0;
    endtask

    task automatic cycle();
        logic e_rdy, e_wr, ob;
        logic [63:0] act, expv;
        if (auto_empty) img_out_empty = (pend <= 0);
        #1;
        e_rdy = m_active && (m_in < TOTAL) && !image_full;
        e_wr  = src_valid && e_rdy;
        act  = 64'({busy, frame_done, timeout, src_ready, image_wr_en, image_din, in_count, out_count});
        expv = 64'({m_active, m_done, m_to, e_rdy, e_wr, src_data, PW'(m_in), PW'(m_out)});
        chk("model", act, expv);
        ob = img_out_rd_en && !img_out_empty;
        if (m_active) begin
            if (e_wr && m_in < TOTAL) m_in++;
            if (ob && m_out < TOTAL)  m_out++;
            pend = pend + (e_wr ? 1 : 0) - (ob ? 1 : 0);
            if (m_in == TOTAL && m_out == TOTAL) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
`ifdef CANNY_FRAME_WDT_EN
            else if (e_wr || ob) m_stall = 0;
            else begin
                m_stall++;
                if (m_stall == WDT) begin
                    m_active = 1'b0;
                    m_to     = 1'b1;
                    m_stall  = 0;
                end
            end
`endif
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
            m_active = 1'b1;
            m_in = 0; m_out = 0; m_to = 1'b0; m_stall = 0; pend = 0;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        model_clear();
        repeat (n) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic feed(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            src_valid = 1'b1;
            src_data  = 24'(k);
            cycle();
        end
        src_valid = 1'b0;
    endtask

    task automatic drain(input int n, output int dones);
        dones = 0;
        src_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (frame_done) dones++;
        end
    endtask

    task automatic arm();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit reached: got running want finished");
        $fatal(1, "time limit");
    end

    initial begin
        int dones, rand_frames;
        //          st  vl  d       full rd   emp   rdy  wr   busy done in out
        tbl[0]  = '{1'b1,1'b0,24'd0, 1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 0,0};
        tbl[1]  = '{1'b0,1'b1,24'd1, 1'b0,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b0, 0,0};
        tbl[2]  = '{1'b0,1'b1,24'd2, 1'b0,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b0, 1,0};
        tbl[3]  = '{1'b0,1'b1,24'd3, 1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0, 2,0};
        tbl[4]  = '{1'b0,1'b1,24'd4, 1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0, 3,1};
        tbl[5]  = '{1'b1,1'b1,24'd5, 1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0, 4,2};
        tbl[6]  = '{1'b0,1'b1,24'd6, 1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0, 5,3};
        tbl[7]  = '{1'b0,1'b1,24'd7, 1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0, 6,4};
        tbl[8]  = '{1'b0,1'b1,24'd8, 1'b0,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0, 7,5};
        tbl[9]  = '{1'b1,1'b1,24'd9, 1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0, 8,6};
        tbl[10] = '{1'b0,1'b1,24'd10,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0, 8,7};
        tbl[11] = '{1'b1,1'b1,24'd11,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1, 8,8};
        tbl[12] = '{1'b0,1'b0,24'd0, 1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 8,8};
        tbl[13] = '{1'b0,1'b0,24'd0, 1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 8,8};

        start = 1'b0; src_valid = 1'b0; src_data = '0; image_full = 1'b0;
        img_out_empty = 1'b1; img_out_rd_en = 1'b0; auto_empty = 1'b0;
        reset = 1'b1;
        model_clear();
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst_busy",  64'(busy), 64'(0));
        chk("rst_done",  64'(frame_done), 64'(0));
        chk("rst_ready", 64'(src_ready), 64'(0));
        chk("rst_wr",    64'(image_wr_en), 64'(0));
        chk("rst_to",    64'(timeout), 64'(0));
        chk("rst_in",    64'(in_count), 64'(0));
        chk("rst_out",   64'(out_count), 64'(0));
        @(negedge clock);
        reset = 1'b0;

        // Directed frame: pixels 1..8, restart attempts in LOAD, DRAIN and DONE.
        for (int r = 0; r < 14; r++) begin
            start = tbl[r].st; src_valid = tbl[r].vl; src_data = tbl[r].d;
            image_full = tbl[r].full; img_out_rd_en = tbl[r].rd; img_out_empty = tbl[r].emp;
            #1;
            chk($sformatf("t%0d_ready", r), 64'(src_ready),   64'(tbl[r].e_rdy));
            chk($sformatf("t%0d_wr", r),    64'(image_wr_en), 64'(tbl[r].e_wr));
            chk($sformatf("t%0d_busy", r),  64'(busy),        64'(tbl[r].e_busy));
            chk($sformatf("t%0d_done", r),  64'(frame_done),  64'(tbl[r].e_done));
            chk($sformatf("t%0d_in", r),    64'(in_count),    64'(tbl[r].e_in));
            chk($sformatf("t%0d_out", r),   64'(out_count),   64'(tbl[r].e_out));
            if (tbl[r].e_wr) chk($sformatf("t%0d_din", r), 64'(image_din), 64'(tbl[r].d));
            cycle();
        end

        // Input FIFO full for 5 cycles after pixel 3.
        auto_empty = 1'b1; img_out_rd_en = 1'b1;
        arm();
        feed(1, 3);
        image_full = 1'b1; src_valid = 1'b1; src_data = 24'd4;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("full_ready", 64'(src_ready), 64'(0));
            chk("full_wr",    64'(image_wr_en), 64'(0));
            chk("full_in",    64'(in_count), 64'(3));
            cycle();
        end
        image_full = 1'b0;
        feed(4, 8);
        drain(12, dones);
        chk("full_dones", 64'(dones), 64'(1));
        chk("full_in8",   64'(in_count), 64'(8));
        chk("full_out8",  64'(out_count), 64'(8));

        // Asynchronous reset in the middle of LOAD.
        img_out_rd_en = 1'b0;
        arm();
        feed(1, 3);
        chk("pre_rst_in", 64'(in_count), 64'(3));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_in",    64'(in_count), 64'(0));
        chk("arst_busy",  64'(busy), 64'(0));
        chk("arst_ready", 64'(src_ready), 64'(0));
        model_clear();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        img_out_rd_en = 1'b1;
        arm();
        feed(1, 8);
        drain(12, dones);
        chk("post_rst_dones", 64'(dones), 64'(1));
        chk("post_rst_in",    64'(in_count), 64'(8));
        chk("post_rst_out",   64'(out_count), 64'(8));

`ifdef CANNY_FRAME_WDT_EN
        // Source stalls after 3 pixels with the sink idle.
        img_out_rd_en = 1'b0;
        arm();
        feed(1, 3);
        repeat (15) cycle();
        chk("wdt_pre_to",   64'(timeout), 64'(0));
        chk("wdt_pre_busy", 64'(busy), 64'(1));
        cycle();
        chk("wdt_to",   64'(timeout), 64'(1));
        chk("wdt_busy", 64'(busy), 64'(0));
        chk("wdt_done", 64'(frame_done), 64'(0));
        drain(2, dones);
        chk("wdt_no_done", 64'(dones), 64'(0));
        chk("wdt_sticky",  64'(timeout), 64'(1));
        arm();
        chk("wdt_clear", 64'(timeout), 64'(0));
        do_reset(2);
`endif

        // Random traffic against the model, alternating FIFO-like and arbitrary sink behaviour.
        rand_frames = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 400 == 0) begin
                do_reset(2);
                auto_empty = (i % 800 == 0);
            end
            start         = ($urandom_range(0, 5) == 0);
            src_valid     = ($urandom_range(0, 3) != 0);
            src_data      = 24'($urandom);
            image_full    = ($urandom_range(0, 4) == 0);
            img_out_rd_en = ($urandom_range(0, 2) != 0);
            if (!auto_empty) img_out_empty = ($urandom_range(0, 2) == 0);
            cycle();
            if (frame_done) rand_frames++;
        end
        chk("rand_frames_seen", 64'(rand_frames > 20), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
